gb48_64_sched: RTL and testbench

//  Sequencing controller for the 48->64 gearbox in the PCS transmit path. Sits between the
//  48-bit upstream source and the gearbox: paces source accepts, forwards the downstream 64-bit

---
 rtl/gb48_64_sched.sv | 146 ++++++++++++++
 tb/tb_gb48_64_sched.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/gb48_64_sched.sv
// Sequencing controller for the 48->64 PCS transmit gearbox: paces source accepts, drives
// end-of-stream padding/drain and mirrors gearbox fill. Optional stats ports: GB_SCHED_STATS_EN.
module gb48_64_sched #(
    parameter int DRAIN_TMO = 16,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             src_valid,
    output logic             src_ready,
    input  logic             sink_ready,
    input  logic             flush_req,
    output logic             gb_enable,
    output logic             gb_datavalid,
    output logic             gb_pad_sel,
    output logic             gb_in_idle,
    input  logic             gb_out_idle,
    input  logic             gb_empty_save,
    input  logic             gb_out_valid,
    output logic             busy,
    output logic             flush_done,
    output logic             err
`ifdef GB_SCHED_STATS_EN
    ,
    output logic [CNT_W-1:0] st_in_words,
    output logic [CNT_W-1:0] st_out_words,
    output logic [CNT_W-1:0] st_pad_words
`endif
);

    localparam int TMO_W = (DRAIN_TMO > 1) ? $clog2(DRAIN_TMO) : 1;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        RUN         = 2'd1,
        FLUSH_PAD   = 2'd2,
        FLUSH_DRAIN = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [3:0]       level;
    logic [4:0]       level_nxt;
    logic [TMO_W-1:0] tmo_cnt, tmo_nxt;
    logic             acc, out, tmo_hit, mismatch;

    always_comb begin
        gb_enable    = enable;
        busy         = (state != IDLE);
        gb_in_idle   = sink_ready & busy;
        src_ready    = 1'b0;
        gb_datavalid = 1'b0;
        gb_pad_sel   = 1'b0;
        case (state)
            RUN: begin
                src_ready    = gb_out_idle & enable;
                gb_datavalid = src_valid & gb_out_idle & enable;
            end
            FLUSH_PAD: begin
                gb_pad_sel   = 1'b1;
                gb_datavalid = gb_out_idle & enable;
            end
            default: ;
        endcase
    end

    // Fill mirror: +3 units per 48-bit word in, -4 units per 64-bit word out.
    always_comb begin
        acc       = gb_datavalid & enable;
        out       = (level >= 4'd4) & gb_in_idle & enable;
        level_nxt = {1'b0, level} + (acc ? 5'd3 : 5'd0) - (out ? 5'd4 : 5'd0);
    end

    always_comb begin
        state_nxt  = state;
        tmo_nxt    = tmo_cnt;
        tmo_hit    = 1'b0;
        flush_done = 1'b0;
        case (state)
            IDLE: state_nxt = RUN;
            RUN: begin
                if (flush_req) begin
                    state_nxt = (level_nxt[1:0] != 2'd0) ? FLUSH_PAD : FLUSH_DRAIN;
                    tmo_nxt   = '0;
                end
            end
            FLUSH_PAD: begin
                if (level_nxt[1:0] == 2'd0) begin
                    state_nxt = FLUSH_DRAIN;
                    tmo_nxt   = '0;
                end
            end
            FLUSH_DRAIN: begin
                if (level_nxt == 5'd0) begin
                    state_nxt  = IDLE;
                    flush_done = enable;
                end else if (tmo_cnt == TMO_W'(DRAIN_TMO - 1)) begin
                    state_nxt = IDLE;
                    tmo_hit   = 1'b1;
                end else begin
                    tmo_nxt = tmo_cnt + TMO_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Any disagreement between the mirror and the gearbox status lines latches err.
    always_comb begin
        mismatch = (gb_out_valid != out)
                 | (gb_out_idle != (level <= 4'd6))
                 | (gb_empty_save != ((level == 4'd0) | (level == 4'd3) |
                                      (level == 4'd6) | (level == 4'd9)))
                 | (level_nxt > 5'd9)
                 | tmo_hit;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            level   <= 4'd0;
            tmo_cnt <= '0;
            err     <= 1'b0;
        end else if (enable) begin
            state   <= state_nxt;
            level   <= level_nxt[3:0];
            tmo_cnt <= tmo_nxt;
            if (mismatch) err <= 1'b1;
        end
    end

`ifdef GB_SCHED_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st_in_words  <= '0;
            st_out_words <= '0;
            st_pad_words <= '0;
        end else if (enable) begin
            if (acc & ~gb_pad_sel) st_in_words  <= st_in_words + CNT_W'(1);
            if (out)               st_out_words <= st_out_words + CNT_W'(1);
            if (acc & gb_pad_sel)  st_pad_words <= st_pad_words + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_gb48_64_sched.sv
// Directed bench for gb48_64_sched with a behavioural gearbox and a per-cycle
// expected-output scoreboard.
module tb_gb48_64_sched;

    localparam int DRAIN_TMO = 16;

    logic clk = 1'b0;
    logic reset_n, enable, src_valid, sink_ready, flush_req, force_ov;
    logic src_ready, gb_enable, gb_datavalid, gb_pad_sel, gb_in_idle, busy, flush_done, err;
    logic gb_out_idle, gb_empty_save, gb_out_valid, g_out;
    logic [3:0] glevel;
`ifdef GB_SCHED_STATS_EN
    logic [31:0] st_in_words, st_out_words, st_pad_words;
`endif

    typedef enum {M_IDLE, M_RUN, M_PAD, M_DRAIN} mstate_t;
    typedef struct packed {
        logic ready, dv, pad, inidle, busy, done, err, gben;
    } exp_t;

    mstate_t m_state;
    logic    m_err;
    int      m_tmo;
    exp_t    exp_q[$];
    int      checks_total = 0, checks_passed = 0;
    int      n_acc, n_out, n_pad, n_done, n_inidle;

    always #5 clk = ~clk;

    gb48_64_sched #(.DRAIN_TMO(DRAIN_TMO), .CNT_W(32)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .src_valid(src_valid), .src_ready(src_ready), .sink_ready(sink_ready),
        .flush_req(flush_req), .gb_enable(gb_enable), .gb_datavalid(gb_datavalid),
        .gb_pad_sel(gb_pad_sel), .gb_in_idle(gb_in_idle), .gb_out_idle(gb_out_idle),
        .gb_empty_save(gb_empty_save), .gb_out_valid(gb_out_valid),
        .busy(busy), .flush_done(flush_done), .err(err)
`ifdef GB_SCHED_STATS_EN
        , .st_in_words(st_in_words), .st_out_words(st_out_words), .st_pad_words(st_pad_words)
`endif
    );

    // Behavioural gearbox: fill in 16-bit units, status lines derived from it.
    assign g_out         = (glevel >= 4'd4) && gb_in_idle && enable;
    assign gb_out_idle   = (glevel <= 4'd6);
    assign gb_empty_save = (glevel == 4'd0) || (glevel == 4'd3) || (glevel == 4'd6) || (glevel == 4'd9);
    assign gb_out_valid  = g_out | force_ov;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) glevel <= 4'd0;
        else if (enable) glevel <= glevel + (gb_datavalid ? 4'd3 : 4'd0) - (g_out ? 4'd4 : 4'd0);
    end

    task automatic chk(string name, int got, int expv);
        checks_total++;
        assert (got === expv) checks_passed++;
        else $error("[TB] FAIL %s got=%0d exp=%0d", name, got, expv);
    endtask

    task automatic checkOutput(string tag);
        exp_t e;
        e = exp_q.pop_front();
        chk({tag, ".src_ready"},    src_ready,    e.ready);
        chk({tag, ".gb_datavalid"}, gb_datavalid, e.dv);
        chk({tag, ".gb_pad_sel"},   gb_pad_sel,   e.pad);
        chk({tag, ".gb_in_idle"},   gb_in_idle,   e.inidle);
        chk({tag, ".busy"},         busy,         e.busy);
        chk({tag, ".flush_done"},   flush_done,   e.done);
        chk({tag, ".err"},          err,          e.err);
        chk({tag, ".gb_enable"},    gb_enable,    e.gben);
    endtask

    task automatic applyStimulus(string tag, logic en, logic sv, logic sr, logic fr, logic fov);
        exp_t       e;
        logic       acc, out, nerr;
        logic [4:0] lnext;
        mstate_t    ns;
        int         ntmo;
        enable = en; src_valid = sv; sink_ready = sr; flush_req = fr; force_ov = fov;
        e.busy   = (m_state != M_IDLE);
        e.inidle = sr & e.busy;
        e.ready  = (m_state == M_RUN) & (glevel <= 4'd6) & en;
        e.dv     = (m_state == M_RUN) ? (sv & e.ready) :
                   (m_state == M_PAD) ? ((glevel <= 4'd6) & en) : 1'b0;
        e.pad    = (m_state == M_PAD);
        acc      = e.dv & en;
        out      = (glevel >= 4'd4) & e.inidle & en;
        lnext    = {1'b0, glevel} + (acc ? 5'd3 : 5'd0) - (out ? 5'd4 : 5'd0);
        e.done   = (m_state == M_DRAIN) & en & (lnext == 5'd0);
        e.err    = m_err;
        e.gben   = en;
        exp_q.push_back(e);
        ns = m_state; ntmo = m_tmo; nerr = m_err | (fov & ~out) | (lnext > 5'd9);
        case (m_state)
            M_IDLE: ns = M_RUN;
            M_RUN: if (fr) begin ns = (lnext[1:0] != 2'd0) ? M_PAD : M_DRAIN; ntmo = 0; end
            M_PAD: if (lnext[1:0] == 2'd0) begin ns = M_DRAIN; ntmo = 0; end
            M_DRAIN: begin
                if (lnext == 5'd0) ns = M_IDLE;
                else if (m_tmo == DRAIN_TMO - 1) begin ns = M_IDLE; nerr = 1'b1; end
                else ntmo = m_tmo + 1;
            end
            default: ns = M_IDLE;
        endcase
        @(negedge clk);
        checkOutput(tag);
        n_acc    += int'(gb_datavalid);
        n_out    += int'(gb_out_valid);
        n_pad    += int'(gb_datavalid & gb_pad_sel);
        n_done   += int'(flush_done);
        n_inidle += int'(gb_in_idle);
        @(posedge clk);
        if (reset_n && en) begin
            m_state = ns; m_tmo = ntmo; m_err = nerr;
        end
        #1;
    endtask

    task automatic clearCounts();
        n_acc = 0; n_out = 0; n_pad = 0; n_done = 0; n_inidle = 0;
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        m_state = M_IDLE; m_err = 1'b0; m_tmo = 0;
        applyStimulus("reset", 0, 0, 0, 0, 0);
        applyStimulus("reset", 0, 0, 0, 0, 0);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b1; enable = 0; src_valid = 0; sink_ready = 0; flush_req = 0; force_ov = 0;
        m_state = M_IDLE; m_err = 1'b0; m_tmo = 0;
        clearCounts();
        #2;

        $display("[TB] streaming cadence");
        doReset();
        applyStimulus("t1", 1, 1, 1, 0, 0);
        applyStimulus("t1", 1, 1, 1, 0, 0);
        applyStimulus("t1.hold", 0, 1, 1, 0, 0);
        clearCounts();
        repeat (16) applyStimulus("t1", 1, 1, 1, 0, 0);
        chk("t1.accepts", n_acc, 16);
        chk("t1.outputs", n_out, 12);

        $display("[TB] sink stalled");
        doReset();
        clearCounts();
        repeat (7) applyStimulus("t2", 1, 1, 0, 0, 0);
        chk("t2.accepts", n_acc, 3);
        chk("t2.in_idle", n_inidle, 0);
        chk("t2.src_ready_final", src_ready, 0);

        $display("[TB] flush at level 5");
        applyStimulus("t3", 1, 0, 1, 0, 0);
        clearCounts();
        applyStimulus("t3.req", 1, 0, 0, 1, 0);
        repeat (3) applyStimulus("t3", 1, 0, 1, 0, 0);
        chk("t3.pads", n_pad, 1);
        chk("t3.outputs", n_out, 2);
        chk("t3.done", n_done, 1);

        $display("[TB] flush at level 6 with stalled sink");
        repeat (2) applyStimulus("t4", 1, 1, 0, 0, 0);
        clearCounts();
        applyStimulus("t4.req", 1, 0, 0, 1, 0);
        repeat (4) applyStimulus("t4.stall", 1, 0, 0, 0, 0);
        repeat (3) applyStimulus("t4", 1, 0, 1, 0, 0);
        applyStimulus("t4", 1, 0, 0, 0, 0);
        chk("t4.pads", n_pad, 2);
        chk("t4.outputs", n_out, 3);
        chk("t4.done", n_done, 1);

        $display("[TB] spurious out_valid");
        repeat (2) applyStimulus("t5", 1, 1, 0, 0, 0);
        applyStimulus("t5", 1, 0, 1, 0, 0);
        applyStimulus("t5.force", 1, 0, 1, 0, 1);
        repeat (3) applyStimulus("t5.sticky", 1, 0, 1, 0, 0);
        chk("t5.err_set", err, 1);
        doReset();
        chk("t5.err_cleared", err, 0);

        $display("[TB] drain timeout");
        repeat (4) applyStimulus("t6", 1, 1, 0, 0, 0);
        repeat (2) applyStimulus("t6", 1, 1, 1, 0, 0);
        clearCounts();
        applyStimulus("t6.req", 1, 0, 0, 1, 0);
        repeat (DRAIN_TMO) applyStimulus("t6.drain", 1, 0, 0, 0, 0);
        applyStimulus("t6.idle", 1, 0, 0, 0, 0);
        chk("t6.done", n_done, 0);
        chk("t6.err", err, 1);

        $display("[TB] reset mid-flush");
        applyStimulus("t7.req", 1, 0, 0, 1, 0);
        applyStimulus("t7.drain", 1, 0, 0, 0, 0);
        doReset();
        chk("t7.busy", busy, 0);

        $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
